// File: rtl/axi_ar_pkg.sv
// Shared AXI AR definitions: default widths, request entry type and sizing helper.
package axi_ar_pkg;

    localparam int unsigned AR_N_SRC        = 4;
    localparam int unsigned AR_ID_WIDTH     = 8;
    localparam int unsigned AR_ADDR_WIDTH   = 32;
    localparam int unsigned AR_LEN_WIDTH    = 8;
    localparam int unsigned AR_SIZE_WIDTH   = 3;
    localparam int unsigned AR_BURST_WIDTH  = 2;
    localparam int unsigned AR_QOS_WIDTH    = 4;
    localparam int unsigned AR_STARVE_LIMIT = 16;

    // One AR request at the default widths.
    typedef struct packed {
        logic [AR_ID_WIDTH-1:0]    id;
        logic [AR_ADDR_WIDTH-1:0]  addr;
        logic [AR_LEN_WIDTH-1:0]   len;
        logic [AR_SIZE_WIDTH-1:0]  size;
        logic [AR_BURST_WIDTH-1:0] burst;
        logic [AR_QOS_WIDTH-1:0]   qos;
    } ar_entry_t;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ar_qos_arbiter_rr_prio_pick.sv
// Round-robin picker: one-hot grant of the first request at or after ptr_i, wrapping.
module rr_prio_pick
    import axi_ar_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic found;
    int   idx;

    // Scan N positions starting at the pointer; first hit wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < int'(N); off++) begin
            idx = (int'(ptr_i) + off) % int'(N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ar_qos_arbiter.sv
// QoS arbiter for AXI AR: highest QoS, round-robin among ties, starvation override.
// The granted source index is prepended to the ID so responses can be routed back.
module ar_qos_arbiter
    import axi_ar_pkg::*;
#(
    parameter int unsigned N_SRC        = AR_N_SRC,
    parameter int unsigned ID_WIDTH     = AR_ID_WIDTH,
    parameter int unsigned ADDR_WIDTH   = AR_ADDR_WIDTH,
    parameter int unsigned LEN_WIDTH    = AR_LEN_WIDTH,
    parameter int unsigned SIZE_WIDTH   = AR_SIZE_WIDTH,
    parameter int unsigned BURST_WIDTH  = AR_BURST_WIDTH,
    parameter int unsigned QOS_WIDTH    = AR_QOS_WIDTH,
    parameter int unsigned STARVE_LIMIT = AR_STARVE_LIMIT,
    localparam int unsigned SRC_W       = clog2_min1(N_SRC)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_SRC-1:0]               src_valid_i,
    output logic [N_SRC-1:0]               src_ready_o,
    input  logic [N_SRC*ID_WIDTH-1:0]      src_id_i,
    input  logic [N_SRC*ADDR_WIDTH-1:0]    src_addr_i,
    input  logic [N_SRC*LEN_WIDTH-1:0]     src_len_i,
    input  logic [N_SRC*SIZE_WIDTH-1:0]    src_size_i,
    input  logic [N_SRC*BURST_WIDTH-1:0]   src_burst_i,
    input  logic [N_SRC*QOS_WIDTH-1:0]     src_qos_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [SRC_W+ID_WIDTH-1:0]      m_id_o,
    output logic [ADDR_WIDTH-1:0]          m_addr_o,
    output logic [LEN_WIDTH-1:0]           m_len_o,
    output logic [SIZE_WIDTH-1:0]          m_size_o,
    output logic [BURST_WIDTH-1:0]         m_burst_o,
    output logic [QOS_WIDTH-1:0]           m_qos_o
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [SRC_W+ID_WIDTH-1:0] id;
        logic [ADDR_WIDTH-1:0]     addr;
        logic [LEN_WIDTH-1:0]      len;
        logic [SIZE_WIDTH-1:0]     size;
        logic [BURST_WIDTH-1:0]    burst;
        logic [QOS_WIDTH-1:0]      qos;
    } entry_t;

    logic [QOS_WIDTH-1:0] max_qos;
    logic [N_SRC-1:0]     urgent, top_qos, cand, grant, fire_vec;
    logic [CNT_W-1:0]     cnt_q [N_SRC];
    logic [CNT_W-1:0]     cnt_d [N_SRC];
    logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d, g_idx;
    logic                 m_valid_q, m_valid_d, load_en, fire;
    entry_t               m_q, m_d, sel;

    // Candidate set: urgent sources if any, otherwise valid sources at the top QoS.
    always_comb begin
        max_qos = '0;
        urgent  = '0;
        top_qos = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (src_valid_i[i] && (src_qos_i[i*QOS_WIDTH +: QOS_WIDTH] > max_qos)) begin
                max_qos = src_qos_i[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
        for (int i = 0; i < int'(N_SRC); i++) begin
            urgent[i]  = src_valid_i[i] && (cnt_q[i] == CNT_W'(STARVE_LIMIT));
            top_qos[i] = src_valid_i[i] && (src_qos_i[i*QOS_WIDTH +: QOS_WIDTH] == max_qos);
        end
        cand = (|urgent) ? urgent : top_qos;
    end

    rr_prio_pick #(
        .N  (N_SRC),
        .PW (SRC_W)
    ) u_pick (
        .req_i (cand),
        .ptr_i (rr_ptr_q),
        .gnt_o (grant)
    );

    // Ready only when the output slot can take a new entry; forced low in reset.
    always_comb begin
        load_en     = ~m_valid_q | m_ready_i;
        src_ready_o = rst ? '0 : (grant & {N_SRC{load_en}});
        fire_vec    = src_valid_i & src_ready_o;
        fire        = |fire_vec;
    end

    // Mux the granted source's fields, tagging the ID with the source index.
    always_comb begin
        sel   = '0;
        g_idx = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (grant[i]) begin
                g_idx     = SRC_W'(i);
                sel.id    = {SRC_W'(i), src_id_i[i*ID_WIDTH +: ID_WIDTH]};
                sel.addr  = src_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel.len   = src_len_i[i*LEN_WIDTH +: LEN_WIDTH];
                sel.size  = src_size_i[i*SIZE_WIDTH +: SIZE_WIDTH];
                sel.burst = src_burst_i[i*BURST_WIDTH +: BURST_WIDTH];
                sel.qos   = src_qos_i[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
    end

    // Output slot and round-robin pointer next state; payload holds on drain.
    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid_q;
        rr_ptr_d  = rr_ptr_q;
        if (fire) begin
            m_d       = sel;
            m_valid_d = 1'b1;
            rr_ptr_d  = (g_idx == SRC_W'(N_SRC - 1)) ? '0 : g_idx + SRC_W'(1);
        end else if (load_en) begin
            m_valid_d = 1'b0;
        end
    end

    // Wait counters: clear on own fire or when idle, else saturate at the limit.
    always_comb begin
        for (int i = 0; i < int'(N_SRC); i++) begin
            cnt_d[i] = cnt_q[i];
            if (fire_vec[i] || !src_valid_i[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_q       <= '0;
            rr_ptr_q  <= '0;
            for (int i = 0; i < int'(N_SRC); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            m_valid_q <= m_valid_d;
            m_q       <= m_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int i = 0; i < int'(N_SRC); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_id_o    = m_q.id;
    assign m_addr_o  = m_q.addr;
    assign m_len_o   = m_q.len;
    assign m_size_o  = m_q.size;
    assign m_burst_o = m_q.burst;
    assign m_qos_o   = m_q.qos;

endmodule
